// File: rtl/mult_stream_pkg.sv
// Shared widths and default sizing for the streaming multiplier controller.
// Imported by mult_res_fifo and mult_stream_ctrl.
package mult_stream_pkg;

    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    localparam int DEF_MUL_LAT = 5;
    localparam int DEF_DEPTH   = 8;

endpackage

// File: rtl/mult_res_fifo.sv
// First-word-fall-through result buffer with occupancy count.
// Head entry is presented on dout; dout reads as zero when empty.
module mult_res_fifo
    import mult_stream_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = PROD_W,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = empty ? '0 : mem[rd_ptr];

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_stream_ctrl.sv
// Credit-based stream controller around an external pipelined multiplier.
// Optional statistics counters are enabled by MULT_STREAM_STATS_EN.
module mult_stream_ctrl
    import mult_stream_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p
`ifdef MULT_STREAM_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_done,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CRW = $clog2(DEPTH + 1);

    logic [MUL_LAT-1:0] vld_sr;
    logic [CRW-1:0]     credit;
    logic               fire;
    logic               pop;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CRW-1:0]     fifo_count;

    assign mul_a     = in_a;
    assign mul_b     = in_b;
    assign in_ready  = (credit != '0);
    assign fire      = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign fifo_push = vld_sr[MUL_LAT-1] && !fifo_full;

    // Track which cycles carry a real operation through the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= fire;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // One credit per buffer entry, reserved at issue, returned on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CRW'(DEPTH);
        end else if (fire && !pop) begin
            credit <= credit - 1'b1;
        end else if (pop && !fire) begin
            credit <= credit + 1'b1;
        end
    end

    mult_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PROD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (mul_p),
        .pop   (pop && !fifo_empty),
        .dout  (out_p),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef MULT_STREAM_STATS_EN
    // Free-running wrap-around activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_done   <= '0;
            stat_stall  <= '0;
        end else begin
            stat_issued <= stat_issued + 32'(fire);
            stat_done   <= stat_done + 32'(pop);
            stat_stall  <= stat_stall + 32'(in_valid && !in_ready);
        end
    end
`endif

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Scoreboard bench for mult_stream_ctrl with a modelled pipelined multiplier.
// Expected products and timing come from a queue of issued operations.
module tb_mult_stream_ctrl;
    import mult_stream_pkg::*;

    localparam int LAT = DEF_MUL_LAT;
    localparam int DEP = DEF_DEPTH;

    typedef struct {
        int          rdy;
        logic [63:0] p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
`ifdef MULT_STREAM_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_done;
    logic [31:0] stat_stall;
`endif

    exp_t q[$];
    int   cyc = 0;
    int   n_fire = 0;
    int   n_pop = 0;
    int   n_stall = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mult_stream_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_p       (out_p)
`ifdef MULT_STREAM_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_done   (stat_done),
        .stat_stall  (stat_stall)
`endif
    );

    // Pipelined multiplier: operands sampled at edge t, product seen at t+LAT.
    logic [63:0] pipe [LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {32'b0, mul_a} * {32'b0, mul_b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[LAT-1];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Issue side: record every accepted operation with its due cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            n_fire = 0;
            n_pop = 0;
            n_stall = 0;
        end else begin
            if (in_valid && in_ready) begin
                q.push_back('{cyc + LAT, {32'b0, in_a} * {32'b0, in_b}});
                n_fire++;
            end
            if (out_valid && out_ready) n_pop++;
            if (in_valid && !in_ready) n_stall++;
        end
    end

    // Monitor: compare presented outputs against the oldest expected result.
    always @(negedge clk) begin
        logic        ev;
        logic [63:0] ep;
        if (!rst) begin
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            ep = ev ? q[0].p : 64'd0;
            chk("in_ready", 64'(in_ready), 64'(q.size() < DEP));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_p", out_p, ep);
            chk("no_write_full", 64'(dut.vld_sr[LAT-1] && dut.fifo_full), 64'd0);
            if (ev && out_ready) void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((q.size() != 0 || out_valid) && k < 200) begin
            step();
            k++;
        end
        chk("drain_timeout", 64'(k >= 200), 64'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        do_reset();
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_p", out_p, 64'd0);

        // Single maximal operation and its latency.
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 32'hFFFF_FFFF;
        in_b = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                chk("single_p", out_p, 64'hFFFF_FFFE_0000_0001);
                break;
            end
        end
        chk("single_latency", 64'(lat), 64'(LAT));
        step();
        drain();

        // Back-to-back stream a=i, b=i+1.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_a = 32'(i);
            in_b = 32'(i + 1);
            step();
        end
        chk("stream_fires", 64'(n_fire), 64'(17));
        drain();

        // Backpressure: buffer fills, issue stops after DEP fires.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            step();
        end
        chk("bp_fires", 64'(n_fire), 64'(DEP));
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drain();
        chk("bp_pops", 64'(n_pop), 64'(DEP));
`ifdef MULT_STREAM_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(DEP));
        chk("stat_done", 64'(stat_done), 64'(DEP));
        chk("stat_stall", 64'(stat_stall), 64'(n_stall));
`endif

        // Fire and pop together with one credit left.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEP - 1; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            step();
            chk("credit1_in_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Reset with three in flight and two buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 32'(i + 3);
            in_b = 32'(i + 7);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_mid_quiet", 64'(out_valid), 64'd0);
            chk("rst_mid_ready", 64'(in_ready), 64'd1);
            step();
        end

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = $urandom;
            in_b = $urandom;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
